oam_dma_ctrl: RTL
=================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: cpu_addr_in  input  16  CPU bus address.
REQ-004 SHALL have port: cpu_wr  input  1  CPU write strobe, one cycle per write.
REQ-005 SHALL have port: cpu_data_in  input  8  CPU write data.
REQ-006 SHALL have port: mem_data  input  8  CPU-space read data, valid the cycle after dma_rd (synchronous memory).
REQ-007 SHALL have port: dma_addr  output  16  DMA source address.
REQ-008 SHALL have port: dma_rd  output  1  DMA read request.
REQ-009 SHALL have port: cpu_halt  output  1  stalls CPU while high.
REQ-010 SHALL have port: oam_dma  output  1  OAM write strobe to ppu_toplevel.
REQ-011 SHALL have port: oam_addr  output  8  OAM byte index.
REQ-012 SHALL have port: oam_data_in  output  8  OAM write data.
REQ-013 SHALL have port: busy  output  1  high in any non-IDLE state.

Function
REQ-014 SHALL trigger when cpu_wr=1, cpu_addr_in=16'h4014 and state=IDLE, latching page=cpu_data_in and index=0.
REQ-015 SHALL ignore $4014 writes while not IDLE (no page or index change, no restart).
REQ-016 SHALL hold a parity flop cyc_par that toggles every clock; the trigger records cyc_par at the trigger cycle.
REQ-017 SHALL implement states IDLE, DUMMY, ALIGN, READ, WRITE.
REQ-018 Transitions: IDLE -trigger-> DUMMY; DUMMY -> ALIGN if the recorded parity=1 (macro on), else READ; ALIGN -> READ; READ -> WRITE; WRITE -> READ if index!=255, else IDLE.
REQ-019 In READ: dma_rd=1 and dma_addr={page,index}; otherwise dma_rd=0 and dma_addr=0.
REQ-020 In WRITE: oam_dma=1, oam_addr=index, oam_data_in=mem_data; otherwise oam_dma=0 and oam_data_in=0, with oam_addr holding the last index.
REQ-021 SHALL increment index by 1 on leaving WRITE (8-bit, wraps 255->0); exactly 256 writes per transfer.
REQ-022 cpu_halt and busy SHALL be 1 in DUMMY, ALIGN, READ and WRITE, and 0 in IDLE.
REQ-023 Halt length SHALL be 513 cycles for even trigger parity and 514 for odd parity (macro on).
REQ-024 A trigger in the cycle the FSM enters IDLE from WRITE SHALL be accepted on the next cycle only (busy=0 is required first).
REQ-025 Ordinary CPU writes to any address other than 16'h4014 SHALL have no effect.

Reset
REQ-026 When reset=1 at a clock edge: state=IDLE, page=0, index=0, cyc_par=0, and all outputs 0.
REQ-027 Reset mid-transfer SHALL abort immediately with no further oam_dma pulses; cpu_halt=0 the cycle after the reset edge.

Configuration
REQ-028 Macro OAM_DMA_ALIGN_EN defined: the ALIGN state is used per REQ-018 (513/514 cycles).
REQ-029 Macro OAM_DMA_ALIGN_EN undefined: ALIGN is never entered and every transfer takes exactly 513 cycles; cyc_par may be omitted.

Verification
REQ-030 After reset, write 8'h02 to $4014 on an even cycle, with memory[16'h0200+i]=i^8'hA5 -> 256 oam_dma pulses, oam_addr 0..255 with data i^A5, cpu_halt high for 513 cycles.
REQ-031 Same trigger on an odd cycle with the macro on -> cpu_halt high for 514 cycles, first READ delayed one cycle; with the macro off -> 513 cycles.
REQ-032 Write $4014=8'h03 at transfer cycle 100 -> ignored; all 256 addresses still read from page 8'h02.
REQ-033 Assert reset at transfer cycle 200 -> outputs 0 next cycle, no oam_dma afterwards; a new trigger with 8'h07 then performs a complete transfer from 16'h0700.
REQ-034 Write 8'h02 to 16'h4013 and to 16'h2004 -> busy stays 0 and no dma_rd.
REQ-035 Two back-to-back transfers (page 01 then page FF) -> final oam_addr=255, dma_addr peaks at 16'hFFFF, and the index wraps correctly to 0 for the second transfer.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a write to $4014 halts the CPU and copies one 256-byte page into OAM.
// Optional odd-cycle alignment state is enabled by defining OAM_DMA_ALIGN_EN.
module oam_dma_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr_in,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_data_in,
    input  logic [7:0]  mem_data,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    output logic        cpu_halt,
    output logic        oam_dma,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data_in,
    output logic        busy
);

    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DUMMY = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  page;
    logic [7:0]  index;
    logic [7:0]  last_index;
    logic        trigger;

    // Only an idle controller accepts $4014, so a retrigger mid-transfer is dropped.
    assign trigger = cpu_wr && (cpu_addr_in == DMA_REG_ADDR) && (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            page       <= 8'h00;
            index      <= 8'h00;
            last_index <= 8'h00;
        end else begin
            state <= state_next;
            if (trigger) begin
                page  <= cpu_data_in;
                index <= 8'h00;
            end else if (state == WRITE) begin
                index <= index + 8'd1;
            end
            if (state == WRITE) begin
                last_index <= index;
            end
        end
    end

`ifdef OAM_DMA_ALIGN_EN
    logic cyc_par;
    logic trig_par;

    // cyc_par tracks CPU get/put cycles; trig_par remembers the phase at the trigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_par  <= 1'b0;
            trig_par <= 1'b0;
        end else begin
            cyc_par <= ~cyc_par;
            if (trigger) begin
                trig_par <= cyc_par;
            end
        end
    end
`endif

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        dma_rd      = 1'b0;
        dma_addr    = 16'h0000;
        oam_dma     = 1'b0;
        oam_addr    = last_index;
        oam_data_in = 8'h00;
        busy        = (state != IDLE);
        cpu_halt    = (state != IDLE);

        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = DUMMY;
                end
            end
            DUMMY: begin
`ifdef OAM_DMA_ALIGN_EN
                state_next = trig_par ? ALIGN : READ;
`else
                state_next = READ;
`endif
            end
            ALIGN: begin
                state_next = READ;
            end
            READ: begin
                dma_rd     = 1'b1;
                dma_addr   = {page, index};
                state_next = WRITE;
            end
            WRITE: begin
                // mem_data is the byte requested in the preceding READ cycle.
                oam_dma     = 1'b1;
                oam_addr    = index;
                oam_data_in = mem_data;
                state_next  = (index == 8'hFF) ? IDLE : READ;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
